// File: rtl/perf_counter_csr.sv
// Cycle / retired-instruction counters behind a one-cycle-latency CSR read/write port,
// with lo-read shadowing of the hi halves. Optional sticky overflow IRQ: PERF_CNT_OVF_IRQ_EN.
module perf_counter_csr #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              retire,
  input  logic              rd_req,
  input  logic [1:0]        rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef PERF_CNT_OVF_IRQ_EN
  output logic              ovf_irq,
`endif
  output logic              running
);

  localparam int HW = CNT_W - DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            r_state, w_nxt;
  logic [CNT_W-1:0]  r_cyc, r_ins;
  logic [HW-1:0]     r_cyc_sh, r_ins_sh;
  logic              w_cnt_en, w_cyc_wr, w_ins_wr;
  logic [DATA_W-1:0] w_rd_mux;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_nxt = RUN;
      RUN:     if (halt)   w_nxt = HALT;
      HALT:    if (!halt)  w_nxt = RUN;
      default:             w_nxt = IDLE;
    endcase
  end

  // halt is a level freeze: it stops counting on the very edge it is seen, not one later
  assign w_cnt_en = (r_state == RUN) && !halt;
  assign w_cyc_wr = wr_en && !wr_addr[1];
  assign w_ins_wr = wr_en &&  wr_addr[1];

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      2'd0: w_rd_mux = r_cyc[DATA_W-1:0];
      2'd1: w_rd_mux = DATA_W'(r_cyc_sh);
      2'd2: w_rd_mux = r_ins[DATA_W-1:0];
      2'd3: w_rd_mux = DATA_W'(r_ins_sh);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      running  <= 1'b0;
      r_cyc    <= '0;
      r_ins    <= '0;
      r_cyc_sh <= '0;
      r_ins_sh <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      r_state  <= w_nxt;
      running  <= (w_nxt == RUN);
      rd_valid <= rd_req;
      if (rd_req) rd_data <= w_rd_mux;

      // A write to either half suppresses that counter's increment for the cycle
      if (w_cyc_wr) begin
        if (wr_addr[0]) r_cyc[CNT_W-1:DATA_W] <= wr_data[HW-1:0];
        else            r_cyc[DATA_W-1:0]     <= wr_data;
      end else if (w_cnt_en) begin
        r_cyc <= r_cyc + CNT_W'(1);
      end

      if (w_ins_wr) begin
        if (wr_addr[0]) r_ins[CNT_W-1:DATA_W] <= wr_data[HW-1:0];
        else            r_ins[DATA_W-1:0]     <= wr_data;
      end else if (w_cnt_en && retire) begin
        r_ins <= r_ins + CNT_W'(1);
      end

      if (wr_en && wr_addr == 2'd1)       r_cyc_sh <= wr_data[HW-1:0];
      else if (rd_req && rd_addr == 2'd0) r_cyc_sh <= r_cyc[CNT_W-1:DATA_W];

      if (wr_en && wr_addr == 2'd3)       r_ins_sh <= wr_data[HW-1:0];
      else if (rd_req && rd_addr == 2'd2) r_ins_sh <= r_ins[CNT_W-1:DATA_W];
    end
  end

`ifdef PERF_CNT_OVF_IRQ_EN
  logic w_cyc_wrap;
  assign w_cyc_wrap = w_cnt_en && !w_cyc_wr && (&r_cyc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_irq <= 1'b0;
    else if (wr_en && wr_addr == 2'd0)   ovf_irq <= 1'b0;
    else if (w_cyc_wrap)                 ovf_irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_perf_counter_csr.sv
// Directed bench for perf_counter_csr; build with PERF_CNT_OVF_IRQ_EN to also cover the overflow IRQ.
module tb_perf_counter_csr;
  logic        clk = 1'b0;
  logic        rst_n, start, halt, retire, rd_req, wr_en;
  logic [1:0]  rd_addr, wr_addr;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, running;
`ifdef PERF_CNT_OVF_IRQ_EN
  logic        ovf_irq;
`endif
  int pass_cnt = 0;
  int total    = 0;

  perf_counter_csr #(.DATA_W(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .retire(retire),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PERF_CNT_OVF_IRQ_EN
    .ovf_irq(ovf_irq),
`endif
    .running(running));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic v);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
    d = rd_data; v = rd_valid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    #12;
    total++; if (rd_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", rd_valid); else pass_cnt++;
    total++; if (rd_data !== 32'd0) $display("FAIL rst_data got %h exp 0", rd_data); else pass_cnt++;
    total++; if (running !== 1'b0) $display("FAIL rst_running got %b exp 0", running); else pass_cnt++;
`ifdef PERF_CNT_OVF_IRQ_EN
    total++; if (ovf_irq !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf_irq); else pass_cnt++;
`endif
    rst_n = 1'b1;
    repeat (4) tick();
    rd(2'd0, d, v);
    total++; if (v !== 1'b1 || d !== 32'd0) $display("FAIL idle_cyc got v=%b %h exp v=1 0", v, d); else pass_cnt++;
    rd(2'd3, d, v);
    total++; if (d !== 32'd0) $display("FAIL idle_inshi got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_count();
    logic [31:0] d; logic v;
    start = 1'b1; tick(); start = 1'b0;
    total++; if (running !== 1'b1) $display("FAIL run_after_start got %b exp 1", running); else pass_cnt++;
    repeat (10) tick();
    rd(2'd0, d, v);
    total++; if (v !== 1'b1 || d !== 32'd10) $display("FAIL cyc10 got v=%b %0d exp v=1 10", v, d); else pass_cnt++;
    tick();
    total++; if (rd_valid !== 1'b0) $display("FAIL valid_drop got %b exp 0", rd_valid); else pass_cnt++;
    rd(2'd1, d, v);
    total++; if (d !== 32'd0) $display("FAIL cyc_hi0 got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_halt();
    logic [31:0] d; logic v;
    wr(2'd2, 32'd0); wr(2'd3, 32'd0); wr(2'd1, 32'd0); wr(2'd0, 32'd100);
    retire = 1'b1; repeat (5) tick(); retire = 1'b0;
    halt = 1'b1;
    rd(2'd0, d, v);
    total++; if (d !== 32'd105) $display("FAIL halt_entry got %0d exp 105", d); else pass_cnt++;
    total++; if (running !== 1'b0) $display("FAIL halt_running got %b exp 0", running); else pass_cnt++;
    repeat (18) begin retire = ~retire; tick(); end
    rd(2'd0, d, v);
    total++; if (d !== 32'd105) $display("FAIL halt_frozen got %0d exp 105", d); else pass_cnt++;
    rd(2'd2, d, v);
    total++; if (d !== 32'd5) $display("FAIL halt_instret got %0d exp 5", d); else pass_cnt++;
    retire = 1'b0; halt = 1'b0;
    tick();
    total++; if (running !== 1'b1) $display("FAIL resume_running got %b exp 1", running); else pass_cnt++;
    rd(2'd0, d, v);
    total++; if (d !== 32'd105) $display("FAIL resume0 got %0d exp 105", d); else pass_cnt++;
    rd(2'd0, d, v);
    total++; if (d !== 32'd106) $display("FAIL resume1 got %0d exp 106", d); else pass_cnt++;
  endtask

  task automatic test_shadow();
    logic [31:0] d; logic v;
    wr(2'd0, 32'hFFFF_FFFE); wr(2'd1, 32'd0);
    rd(2'd0, d, v);
    total++; if (d !== 32'hFFFF_FFFE) $display("FAIL sh_lo got %h exp fffffffe", d); else pass_cnt++;
    tick(); tick();
    rd(2'd1, d, v);
    total++; if (d !== 32'd0) $display("FAIL sh_hi_stale got %h exp 0", d); else pass_cnt++;
    rd(2'd0, d, v);
    total++; if (d !== 32'd2) $display("FAIL sh_lo2 got %h exp 2", d); else pass_cnt++;
    rd(2'd1, d, v);
    total++; if (d !== 32'd1) $display("FAIL sh_hi_live got %h exp 1", d); else pass_cnt++;
  endtask

  task automatic test_hi_write();
    logic [31:0] d; logic v;
    wr(2'd0, 32'd10); wr(2'd1, 32'd5);
    rd(2'd1, d, v);
    total++; if (d !== 32'd5) $display("FAIL hiwr_shadow got %0d exp 5", d); else pass_cnt++;
    rd(2'd0, d, v);
    total++; if (d !== 32'd11) $display("FAIL hiwr_noinc got %0d exp 11", d); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic v;
    wr(2'd2, 32'd7); wr(2'd3, 32'd0);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h100;
    rd_req = 1'b1; rd_addr = 2'd2; retire = 1'b1;
    tick();
    wr_en = 1'b0; rd_req = 1'b0; retire = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'd7) $display("FAIL rw_old got v=%b %h exp v=1 7", rd_valid, rd_data); else pass_cnt++;
    rd(2'd2, d, v);
    total++; if (d !== 32'h100) $display("FAIL rw_new got %h exp 100", d); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic v;
    wr(2'd2, 32'hFFFF_FFFF); wr(2'd3, 32'hFFFF_FFFF);
    retire = 1'b1; tick(); retire = 1'b0;
    rd(2'd2, d, v);
    total++; if (d !== 32'd0) $display("FAIL ins_wrap_lo got %h exp 0", d); else pass_cnt++;
    rd(2'd3, d, v);
    total++; if (d !== 32'd0) $display("FAIL ins_wrap_hi got %h exp 0", d); else pass_cnt++;
    wr(2'd1, 32'hFFFF_FFFF); wr(2'd0, 32'hFFFF_FFFE);
`ifdef PERF_CNT_OVF_IRQ_EN
    total++; if (ovf_irq !== 1'b0) $display("FAIL ovf_pre got %b exp 0", ovf_irq); else pass_cnt++;
`endif
    tick(); tick();
`ifdef PERF_CNT_OVF_IRQ_EN
    total++; if (ovf_irq !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf_irq); else pass_cnt++;
`endif
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h55;
    rd_req = 1'b1; rd_addr = 2'd0;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    total++; if (rd_data !== 32'd0) $display("FAIL cyc_wrap_lo got %h exp 0", rd_data); else pass_cnt++;
`ifdef PERF_CNT_OVF_IRQ_EN
    total++; if (ovf_irq !== 1'b0) $display("FAIL ovf_clr got %b exp 0", ovf_irq); else pass_cnt++;
`endif
    rd(2'd1, d, v);
    total++; if (d !== 32'd0) $display("FAIL cyc_wrap_hi got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic v;
    rd_req = 1'b1; rd_addr = 2'd2;
    @(posedge clk); #2;
    rd_req = 1'b0;
    total++; if (rd_valid !== 1'b1) $display("FAIL pend_valid got %b exp 1", rd_valid); else pass_cnt++;
    rst_n = 1'b0; #1;
    total++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) $display("FAIL arst_rd got v=%b %h exp v=0 0", rd_valid, rd_data); else pass_cnt++;
    total++; if (running !== 1'b0) $display("FAIL arst_running got %b exp 0", running); else pass_cnt++;
    #2 rst_n = 1'b1;
    tick(); tick();
    rd(2'd0, d, v);
    total++; if (d !== 32'd0) $display("FAIL arst_cyc got %h exp 0", d); else pass_cnt++;
    rd(2'd2, d, v);
    total++; if (d !== 32'd0) $display("FAIL arst_ins got %h exp 0", d); else pass_cnt++;
    rd(2'd0, d, v);
    total++; if (d !== 32'd0 || running !== 1'b0) $display("FAIL arst_idle got %h run=%b exp 0 run=0", d, running); else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rd(2'd0, d, v);
    total++; if (d !== 32'd2 || running !== 1'b1) $display("FAIL restart got %0d run=%b exp 2 run=1", d, running); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; retire = 1'b0;
    rd_req = 1'b0; rd_addr = 2'd0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 32'd0;
    test_reset();
    test_count();
    test_halt();
    test_shadow();
    test_hi_write();
    test_same_cycle();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
